mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-port memory arbiter with burst lock and tagged read return.
// Optional round-robin selection when MEMARB_ROUNDROBIN_EN is defined.
module mem_arbiter #(
  parameter int NPORTS = 3,
  parameter int AW     = 25,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic                 F14Mx2,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    p_req,
  input  logic [NPORTS-1:0]    p_we,
  input  logic [NPORTS-1:0]    p_lock,
  input  logic [NPORTS*AW-1:0] p_addr,
  input  logic [NPORTS*DW-1:0] p_din,
  output logic [NPORTS-1:0]    p_ack,
  output logic [NPORTS-1:0]    p_rvalid,
  output logic [DW-1:0]        p_rdata,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_din,
  output logic                 mem_we,
  output logic                 mem_rd,
  input  logic [DW-1:0]        mem_dout,
  output logic                 busy
);

  localparam int IW = $clog2(NPORTS);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   owner, owner_nxt;
  logic            grant_valid;
  logic [IW-1:0]   grant_idx;
  logic            lock_hold;
  logic [RD_LAT:0] tag_v;
  logic [IW-1:0]   tag_idx [RD_LAT+1];
`ifdef MEMARB_ROUNDROBIN_EN
  logic [IW-1:0]   rr_ptr;
`endif

  always_ff @(posedge F14Mx2) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // A held lock is only honoured while the owner keeps p_lock high; once it
  // drops, normal selection applies in that same cycle.
  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    grant_valid = 1'b0;
    grant_idx   = '0;
    p_ack       = '0;
    lock_hold   = (state == LOCKED) && p_lock[owner];
    if (lock_hold) begin
      grant_valid = p_req[owner];
      grant_idx   = owner;
    end else begin
`ifdef MEMARB_ROUNDROBIN_EN
      for (int k = 1; k <= NPORTS; k++) begin
        int cand;
        cand = int'(rr_ptr) + k;
        if (cand >= NPORTS) cand = cand - NPORTS;
        if (!grant_valid && p_req[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = IW'(cand);
        end
      end
`else
      for (int i = NPORTS - 1; i >= 0; i--) begin
        if (p_req[i]) begin
          grant_valid = 1'b1;
          grant_idx   = IW'(i);
        end
      end
`endif
    end
    if (reset) grant_valid = 1'b0;
    if (grant_valid) p_ack[grant_idx] = 1'b1;
    if (lock_hold) begin
      state_nxt = LOCKED;
    end else if (grant_valid && p_lock[grant_idx]) begin
      state_nxt = LOCKED;
      owner_nxt = grant_idx;
    end else begin
      state_nxt = IDLE;
    end
  end

`ifdef MEMARB_ROUNDROBIN_EN
  always_ff @(posedge F14Mx2) begin
    if (reset) rr_ptr <= IW'(NPORTS - 1);
    else if (grant_valid) rr_ptr <= grant_idx;
  end
`endif

  always_ff @(posedge F14Mx2) begin
    if (reset) begin
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we   <= 1'b0;
      mem_rd   <= 1'b0;
      tag_v    <= '0;
      p_rvalid <= '0;
      p_rdata  <= '0;
    end else begin
      mem_we <= grant_valid && p_we[grant_idx];
      mem_rd <= grant_valid && !p_we[grant_idx];
      if (grant_valid) begin
        mem_addr <= p_addr[grant_idx*AW +: AW];
        mem_din  <= p_din[grant_idx*DW +: DW];
      end
      // Tag stage k lines up with the memory cycle k after mem_rd.
      tag_v      <= {tag_v[RD_LAT-1:0], grant_valid && !p_we[grant_idx]};
      tag_idx[0] <= grant_idx;
      for (int k = 1; k <= RD_LAT; k++) tag_idx[k] <= tag_idx[k-1];
      p_rvalid <= '0;
      if (tag_v[RD_LAT]) begin
        p_rvalid[tag_idx[RD_LAT]] <= 1'b1;
        p_rdata                   <= mem_dout;
      end
    end
  end

  assign busy = (state == LOCKED) || (|tag_v);

endmodule
